// File: rtl/multiplicador_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving an external 4-bit adder.
// One operation takes 4 CALC cycles followed by one FIM cycle with pronto high.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   CALC  | one add-and-shift step per cycle, cnt counts 0..3
//   FIM   | produto holds a fresh result, pronto high for one cycle
module multiplicador_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  output logic       add_cin,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic [7:0] produto,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] m;
  logic [3:0] acc;
  logic [3:0] q;
  logic [1:0] cnt;

  // Adder operands: partial product is M when the current multiplier bit is set.
  assign add_a   = acc;
  assign add_b   = q[0] ? m : 4'h0;
  assign add_cin = 1'b0;

  assign ocupado = (state == CALC);
  assign pronto  = (state == FIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == 2'd3) state_nxt = FIM;
      FIM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, add-and-shift steps, result load on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= 4'h0;
      acc     <= 4'h0;
      q       <= 4'h0;
      cnt     <= 2'd0;
      produto <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= 4'h0;
            cnt <= 2'd0;
          end
        end
        CALC: begin
          acc <= {add_cout, add_s[3:1]};
          q   <= {add_s[0], q[3:1]};
          cnt <= cnt + 2'd1;
          // Final step: the post-shift {ACC,Q} is the product.
          if (cnt == 2'd3) begin
            produto <= {add_cout, add_s, q[3:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq with a behavioural 4-bit adder on add_*.
module tb_multiplicador_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic [3:0] add_s;
  logic       add_cout;
  logic [7:0] produto;
  logic       ocupado;
  logic       pronto;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_prod = 8'h00;
  logic [4:0] sum;

  multiplicador_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .produto  (produto),
    .ocupado  (ocupado),
    .pronto   (pronto)
  );

  always #5 clk = ~clk;

  // Behavioural external adder.
  always_comb begin
    sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
  end
  assign add_s    = sum[3:0];
  assign add_cout = sum[4];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
  endtask

  // Finish an operation whose start is already driven: acceptance edge,
  // four busy cycles, one pronto cycle, back to idle.
  task automatic complete(input logic [3:0] x, input logic [3:0] y, input bit chk);
    logic [7:0] expv;
    expv = {4'h0, x} * {4'h0, y};
    @(posedge clk); #1;
    start = 1'b0;
    a     = 4'($urandom_range(0, 15));
    b     = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      check("add_cin", {7'h0, add_cin}, 8'h00);
      if (chk) begin
        check("ocupado_calc", {7'h0, ocupado}, 8'h01);
        check("pronto_calc", {7'h0, pronto}, 8'h00);
        check("produto_hold", produto, last_prod);
      end
      @(posedge clk); #1;
    end
    check("pronto_fim", {7'h0, pronto}, 8'h01);
    check("ocupado_fim", {7'h0, ocupado}, 8'h00);
    check("produto", produto, expv);
    last_prod = expv;
    @(posedge clk); #1;
    check("pronto_after", {7'h0, pronto}, 8'h00);
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input bit chk);
    launch(x, y);
    complete(x, y, chk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    logic [3:0] rx;
    logic [3:0] ry;

    // Reset state
    #12;
    check("rst_produto", produto, 8'h00);
    check("rst_pronto", {7'h0, pronto}, 8'h00);
    check("rst_ocupado", {7'h0, ocupado}, 8'h00);
    check("rst_add_a", {4'h0, add_a}, 8'h00);
    check("rst_add_b", {4'h0, add_b}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner products
    run_op(4'd15, 4'd15, 1'b1);
    run_op(4'd9, 4'd6, 1'b1);
    run_op(4'd7, 4'd0, 1'b1);
    run_op(4'd1, 4'd1, 1'b1);

    // Start pulse during CALC of 3x5 must be ignored
    launch(4'd3, 4'd5);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 4'd2; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    np = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (pronto) begin
        np++;
        check("ignored_start_produto", produto, 8'h0F);
      end
    end
    check("ignored_start_pulses", 8'(np), 8'h01);
    last_prod = 8'h0F;

    // Reset during the second CALC cycle of 15x15
    launch(4'd15, 4'd15);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_produto", produto, 8'h00);
    check("abort_ocupado", {7'h0, ocupado}, 8'h00);
    check("abort_pronto", {7'h0, pronto}, 8'h00);
    @(posedge clk); #1;
    check("abort_hold_pronto", {7'h0, pronto}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    a = 4'd3; b = 4'd3; start = 1'b1;
    last_prod = 8'h00;
    complete(4'd3, 4'd3, 1'b1);

    // Start held high: one result every 6 cycles, operands changed after capture
    @(negedge clk);
    a = 4'd2; b = 4'd3; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        a = 4'd4; b = 4'd4;
      end
      if (c == 12) start = 1'b0;
      check("stream_pronto", {7'h0, pronto}, ((c % 6) == 5) ? 8'h01 : 8'h00);
      if (c == 5) check("stream_produto1", produto, 8'd2 * 8'd3);
      if (c == 11) check("stream_produto2", produto, 8'd4 * 8'd4);
    end
    last_prod = 8'h10;
    @(posedge clk); #1;
    check("idle_hold_produto", produto, last_prod);
    check("idle_ocupado", {7'h0, ocupado}, 8'h00);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      run_op(rx, ry, 1'b1);
    end

    // Exhaustive sweep
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_op(4'(x), 4'(y), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
